spike_scheduler: RTL and testbench
==================================

Name: spike_scheduler

Overview:
- Ingress stage directly upstream of the neuron grid controller.
- Accepts incoming spike packets (one target axon index each) through a small FIFO and accumulates them into a pending axon bitmap.
- On the controller's scheduler_set, the pending bitmap moves to the active bitmap; the active bit for the current axon is presented as axon_spike during integration.
- Releases the time-step tick to the controller only after every packet received before that tick has been absorbed.

Parameters:
- NUM_AXONS, 256, number of axons; bitmap width.
- AXON_W, 8, width of the axon index; must satisfy 2**AXON_W >= NUM_AXONS.
- FIFO_DEPTH, 4, packet FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- pkt_valid  in  1  spike packet valid.
- pkt_axon  in  AXON_W  target axon index.
- pkt_ready  out  1  FIFO can accept; equals ~fifo_full.
- tick_in  in  1  time-step tick from the SoC, single-cycle pulse.
- wait_packets  in  1  controller idle; high means ingest and tick release are allowed.
- scheduler_set  in  1  pending bitmap to active bitmap, then clear pending.
- scheduler_clr  in  1  clear active bitmap.
- axon_num  in  AXON_W  axon currently processed by the controller.
- tick_out  out  1  tick to the controller.
- axon_spike  out  1  active[axon_num]; 0 if axon_num >= NUM_AXONS.
- pending_empty  out  1  pending bitmap all zero.
- error  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous): FIFO empty, pending=0, active=0, tick_pending=0, error=0. Outputs after reset: pkt_ready=1, tick_out=0, axon_spike=0, pending_empty=1.
- Push: on a clk edge with pkt_valid & pkt_ready, write pkt_axon into the FIFO.
- Full FIFO: pkt_ready=0; the sender holds the packet; no loss.
- Drain (pop): one entry per cycle while FIFO non-empty & wait_packets=1.
  - Popped index < NUM_AXONS: pending[idx] <= 1. Duplicate indices are idempotent.
  - Popped index >= NUM_AXONS: entry discarded, error <= 1.
- Push and pop in the same cycle are both allowed; occupancy is unchanged.
- Drain latency: a packet pushed at edge N sets its pending bit no earlier than edge N+1.
- tick_in: at each edge with tick_in=1, tick_pending <= 1. If tick_pending is already 1 and is not being consumed that cycle, error <= 1; ticks do not queue.
- tick_out is combinational: tick_pending & fifo_empty & wait_packets. At an edge with tick_out=1, tick_pending <= 0, giving exactly one cycle high per tick. Minimum tick_in to tick_out latency is 1 cycle.
- Packets arriving after tick_in but before tick_out are drained first and belong to that time step.
- scheduler_set at an edge: active <= pending; pending <= 0. If a pop occurs in the same cycle, its bit lands in the new pending (the set wins for the old contents). Pops only occur while wait_packets=1, so this case does not arise in normal use, but it is defined.
- scheduler_clr at an edge: active <= 0. If scheduler_set and scheduler_clr are asserted together, set wins for active.
- axon_spike is purely combinational from active and axon_num; zero latency, so the controller samples it in the same cycle.
- tick_in while wait_packets=0 (controller busy): latched in tick_pending and released on return to IDLE. error is not raised unless a second tick arrives.
- error clears only on reset.

Optional Feature:
- Macro SPIKE_SCHEDULER_DROP_CNT_EN.
- When defined: adds output drop_cnt [7:0]. It increments on each discarded out-of-range packet and each rejected duplicate tick, saturates at 255, and resets to 0.
- When undefined: the port and counter are absent; error behaviour is unchanged.

Test Plan:
- Reset, then push axons 3, 7, 3 with wait_packets=1, then scheduler_set. Expect active bits 3 and 7 only; axon_spike=1 for axon_num 3 and 7, 0 for 4; pending_empty=1.
- With FIFO_DEPTH=4 and wait_packets=0, push 5 packets back-to-back. Expect pkt_ready low after 4 accepted; raise wait_packets; all 5 bits end up pending, none lost.
- Push 2 packets, then assert tick_in in the next cycle with wait_packets=1. Expect tick_out only after the FIFO empties, exactly one cycle wide, with both bits already pending.
- Assert tick_in twice, 3 cycles apart, while wait_packets=0. Expect error=1 and a single tick_out when wait_packets rises.
- With NUM_AXONS=200, push axon 250. Expect it discarded, error=1, pending unchanged; with the macro defined, drop_cnt=1.
- Pulse scheduler_clr after active holds bit 5. Expect axon_spike=0 at axon_num=5 next cycle. Then set and clr together with pending bit 9: expect active bit 9 set.

Source files
------------

// File: rtl/spike_scheduler.sv
// -----------------------------------------------------------------------------
// spike_scheduler
//
// Ingress stage in front of the neuron grid controller. Spike packets (one
// target axon index each) enter a small FIFO and are drained into a pending
// axon bitmap while the controller is idle. On scheduler_set the pending
// bitmap becomes the active bitmap, which the controller reads one axon at a
// time through axon_spike. The SoC time-step tick is held back until every
// packet that arrived before it has reached the pending bitmap.
//
// Parameters:
//   NUM_AXONS  - number of axons / bitmap width
//   AXON_W     - axon index width; 2**AXON_W must be >= NUM_AXONS
//   FIFO_DEPTH - packet FIFO entries; power of two, at least 2
//
// Ports:
//   clk            clock
//   reset_n        asynchronous active-low reset
//   pkt_valid      spike packet valid
//   pkt_axon       target axon index of the packet
//   pkt_ready      FIFO can accept a packet (not full)
//   tick_in        time-step tick from the SoC, single-cycle pulse
//   wait_packets   controller idle: draining and tick release allowed
//   scheduler_set  move pending bitmap to active, clear pending
//   scheduler_clr  clear active bitmap (scheduler_set has priority)
//   axon_num       axon currently processed by the controller
//   tick_out       tick to the controller, one cycle per accepted tick
//   axon_spike     active[axon_num], 0 when axon_num is out of range
//   pending_empty  pending bitmap is all zero
//   drop_cnt       (only with SPIKE_SCHEDULER_DROP_CNT_EN) saturating count
//                  of discarded out-of-range packets and rejected ticks
//   error          sticky: out-of-range packet or tick while one is pending
//
// Optional feature macro: SPIKE_SCHEDULER_DROP_CNT_EN adds the drop_cnt port.
// -----------------------------------------------------------------------------
module spike_scheduler #(
    parameter int NUM_AXONS  = 256,
    parameter int AXON_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pkt_valid,
    input  logic [AXON_W-1:0] pkt_axon,
    output logic              pkt_ready,
    input  logic              tick_in,
    input  logic              wait_packets,
    input  logic              scheduler_set,
    input  logic              scheduler_clr,
    input  logic [AXON_W-1:0] axon_num,
    output logic              tick_out,
    output logic              axon_spike,
    output logic              pending_empty,
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic              error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]       PTR_INC       = (PTR_W+1)'(1);
    localparam logic [NUM_AXONS-1:0] AXON_ONE      = NUM_AXONS'(1);
    localparam logic [AXON_W:0]      NUM_AXONS_EXT = (AXON_W+1)'(NUM_AXONS);

    // -------------------------------------------------------------------------
    // Packet FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate occupancy counter.
    // -------------------------------------------------------------------------
    logic [AXON_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [AXON_W-1:0] pop_axon;
    logic              pop_in_range;
    logic              drop_evt;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pkt_ready = ~fifo_full;
    assign push      = pkt_valid & ~fifo_full;
    // Draining is only allowed while the controller is idle.
    assign pop       = ~fifo_empty & wait_packets;

    assign pop_axon     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign pop_in_range = ({1'b0, pop_axon} < NUM_AXONS_EXT);
    assign drop_evt     = pop & ~pop_in_range;

    // NOTE: the FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= pkt_axon;
        end
    end

    // -------------------------------------------------------------------------
    // Bitmaps, tick tracking and error flag
    // -------------------------------------------------------------------------
    logic [NUM_AXONS-1:0] pending_q, pending_d;
    logic [NUM_AXONS-1:0] active_q, active_d;
    logic [NUM_AXONS-1:0] pop_bit;
    logic                 tick_pending_q, tick_pending_d;
    logic                 tick_dup;
    logic                 error_q, error_d;

    // A tick is released only once every earlier packet has been absorbed and
    // the controller is idle.
    assign tick_out = tick_pending_q & fifo_empty & wait_packets;

    // A second tick while one is still waiting (and not leaving this cycle)
    // is rejected; ticks do not queue.
    assign tick_dup = tick_in & tick_pending_q & ~tick_out;

    assign pop_bit = (pop && pop_in_range) ? (AXON_ONE << pop_axon) : '0;

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch so no
        // path leaves it unassigned and no latch is inferred.
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pending_d      = pending_q;
        active_d       = active_q;
        tick_pending_d = tick_pending_q;
        error_d        = error_q | drop_evt | tick_dup;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end

        // scheduler_set takes the old pending contents; a bit popped in the
        // same cycle belongs to the freshly cleared pending map.
        if (scheduler_set) begin
            active_d  = pending_q;
            pending_d = '0;
        end else if (scheduler_clr) begin
            active_d = '0;
        end
        pending_d = pending_d | pop_bit;

        // A new tick wins over the release of the previous one in the same
        // cycle, so a back-to-back tick is never lost.
        if (tick_in) begin
            tick_pending_d = 1'b1;
        end else if (tick_out) begin
            tick_pending_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order of the statements.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            tick_pending_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            tick_pending_q <= tick_pending_d;
            error_q        <= error_d;
        end
    end

    assign error         = error_q;
    assign pending_empty = ~|pending_q;

    // Zero-latency lookup: the controller samples axon_spike in the same cycle
    // it presents axon_num. An index beyond the bitmap shifts the one-hot mask
    // out entirely, which yields 0; the explicit range test documents that.
    logic axon_in_range;
    assign axon_in_range = ({1'b0, axon_num} < NUM_AXONS_EXT);
    assign axon_spike    = axon_in_range & (|(active_q & (AXON_ONE << axon_num)));

`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
    // -------------------------------------------------------------------------
    // Drop counter: a discarded packet and a rejected tick can coincide, so
    // the increment is up to 2 and the sum is saturated at 255.
    // -------------------------------------------------------------------------
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + {8'd0, drop_evt} + {8'd0, tick_dup};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spike_scheduler
//
// Self-checking bench for spike_scheduler (NUM_AXONS=200 so out-of-range
// indices exist). A behavioural model (packet queue, pending/active flag
// arrays, tick and error flags) advances on each clock edge; directed
// scenario tasks and a randomized run compare DUT outputs against it.
// Inputs change after the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_spike_scheduler;

    localparam int NUM_AXONS  = 200;
    localparam int AXON_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              reset_n;
    logic              pkt_valid;
    logic [AXON_W-1:0] pkt_axon;
    logic              pkt_ready;
    logic              tick_in;
    logic              wait_packets;
    logic              scheduler_set;
    logic              scheduler_clr;
    logic [AXON_W-1:0] axon_num;
    logic              tick_out;
    logic              axon_spike;
    logic              pending_empty;
    logic              error;
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    int total;
    int bad;

    spike_scheduler #(
        .NUM_AXONS (NUM_AXONS),
        .AXON_W    (AXON_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pkt_valid    (pkt_valid),
        .pkt_axon     (pkt_axon),
        .pkt_ready    (pkt_ready),
        .tick_in      (tick_in),
        .wait_packets (wait_packets),
        .scheduler_set(scheduler_set),
        .scheduler_clr(scheduler_clr),
        .axon_num     (axon_num),
        .tick_out     (tick_out),
        .axon_spike   (axon_spike),
        .pending_empty(pending_empty),
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [AXON_W-1:0] m_q[$];
    bit                m_pend[NUM_AXONS];
    bit                m_act[NUM_AXONS];
    bit                m_tick;
    bit                m_err;
    int                m_drop;

    bit                mp_push, mp_pop, mp_rel;
    int                mp_idx, mp_drops;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            foreach (m_act[i])  m_act[i]  = 1'b0;
            m_tick = 1'b0;
            m_err  = 1'b0;
            m_drop = 0;
        end else begin
            mp_push  = pkt_valid && (m_q.size() < FIFO_DEPTH);
            mp_pop   = (m_q.size() != 0) && wait_packets;
            mp_rel   = m_tick && (m_q.size() == 0) && wait_packets;
            mp_drops = 0;
            if (scheduler_set) begin
                m_act = m_pend;
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else if (scheduler_clr) begin
                foreach (m_act[i]) m_act[i] = 1'b0;
            end
            if (mp_pop) begin
                mp_idx = int'(m_q.pop_front());
                if (mp_idx < NUM_AXONS) m_pend[mp_idx] = 1'b1;
                else begin
                    m_err = 1'b1;
                    mp_drops++;
                end
            end
            if (mp_push) m_q.push_back(pkt_axon);
            if (tick_in) begin
                if (m_tick && !mp_rel) begin
                    m_err = 1'b1;
                    mp_drops++;
                end
                m_tick = 1'b1;
            end else if (mp_rel) begin
                m_tick = 1'b0;
            end
            m_drop = (m_drop + mp_drops > 255) ? 255 : m_drop + mp_drops;
        end
    end

    function automatic bit exp_ready();
        return m_q.size() < FIFO_DEPTH;
    endfunction

    function automatic bit exp_tick();
        return m_tick && (m_q.size() == 0) && wait_packets;
    endfunction

    function automatic bit exp_spike();
        if (int'(axon_num) >= NUM_AXONS) return 1'b0;
        return m_act[int'(axon_num)];
    endfunction

    function automatic bit exp_pempty();
        foreach (m_pend[i]) if (m_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // -------------------------------------------------------------------------
    task automatic idle_inputs();
        pkt_valid     = 1'b0;
        pkt_axon      = '0;
        tick_in       = 1'b0;
        scheduler_set = 1'b0;
        scheduler_clr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        wait_packets = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push_one(input logic [AXON_W-1:0] a);
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_axon  = a;
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic pulse_set();
        @(negedge clk);
        scheduler_set = 1'b1;
        @(negedge clk);
        scheduler_set = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        wait_packets = 1'b1;
        axon_num     = 8'd3;
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (pkt_ready !== 1'b1) begin bad++; $display("FAIL reset_pkt_ready got=%0b exp=1", pkt_ready); end
        total++; if (tick_out !== 1'b0) begin bad++; $display("FAIL reset_tick_out got=%0b exp=0", tick_out); end
        total++; if (axon_spike !== 1'b0) begin bad++; $display("FAIL reset_axon_spike got=%0b exp=0", axon_spike); end
        total++; if (pending_empty !== 1'b1) begin bad++; $display("FAIL reset_pending_empty got=%0b exp=1", pending_empty); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", error); end
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [AXON_W-1:0] seq [3];
        seq[0] = 8'd3; seq[1] = 8'd7; seq[2] = 8'd3;
        apply_reset();
        wait_packets = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pkt_valid = 1'b1;
            pkt_axon  = seq[i];
            #1;
            total++; if (pkt_ready !== exp_ready()) begin bad++; $display("FAIL basic_pkt_ready got=%0b exp=%0b", pkt_ready, exp_ready()); end
        end
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (pending_empty !== 1'b0) begin bad++; $display("FAIL basic_pending_filled got=%0b exp=0", pending_empty); end
        pulse_set();
        #1;
        total++; if (pending_empty !== 1'b1) begin bad++; $display("FAIL basic_pending_after_set got=%0b exp=1", pending_empty); end
        axon_num = 8'd3; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL basic_spike3 got=%0b exp=1", axon_spike); end
        axon_num = 8'd7; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL basic_spike7 got=%0b exp=1", axon_spike); end
        axon_num = 8'd4; #1;
        total++; if (axon_spike !== 1'b0) begin bad++; $display("FAIL basic_spike4 got=%0b exp=0", axon_spike); end
        for (int a = 0; a < 256; a++) begin
            axon_num = 8'(a); #1;
            total++; if (axon_spike !== exp_spike()) begin bad++; $display("FAIL basic_map axon=%0d got=%0b exp=%0b", a, axon_spike, exp_spike()); end
        end
    endtask

    task automatic test_full();
        int sent;
        sent = 0;
        apply_reset();
        wait_packets = 1'b0;
        for (int cyc = 0; cyc < 40 && sent < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 8) wait_packets = 1'b1;
            pkt_valid = 1'b1;
            pkt_axon  = 8'(10 + sent);
            #1;
            total++; if (pkt_ready !== exp_ready()) begin bad++; $display("FAIL full_pkt_ready cyc=%0d got=%0b exp=%0b", cyc, pkt_ready, exp_ready()); end
            if (cyc >= 4 && cyc <= 8) begin
                total++; if (pkt_ready !== 1'b0) begin bad++; $display("FAIL full_held cyc=%0d got=%0b exp=0", cyc, pkt_ready); end
            end
            if (exp_ready()) sent++;
        end
        total++; if (sent != 5) begin bad++; $display("FAIL full_all_sent got=%0d exp=5", sent); end
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (6) @(negedge clk);
        pulse_set();
        for (int a = 10; a < 15; a++) begin
            axon_num = 8'(a); #1;
            total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL full_bit axon=%0d got=%0b exp=1", a, axon_spike); end
        end
        for (int a = 0; a < 256; a++) begin
            axon_num = 8'(a); #1;
            total++; if (axon_spike !== exp_spike()) begin bad++; $display("FAIL full_map axon=%0d got=%0b exp=%0b", a, axon_spike, exp_spike()); end
        end
    endtask

    task automatic test_tick_drain();
        int highs;
        highs = 0;
        apply_reset();
        wait_packets = 1'b1;
        @(negedge clk); pkt_valid = 1'b1; pkt_axon = 8'd20;
        @(negedge clk); pkt_axon = 8'd21;
        @(negedge clk); pkt_valid = 1'b0; tick_in = 1'b1;
        #1;
        total++; if (tick_out !== 1'b0) begin bad++; $display("FAIL drain_tick_early got=%0b exp=0", tick_out); end
        @(negedge clk); tick_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (tick_out !== exp_tick()) begin bad++; $display("FAIL drain_tick_out c=%0d got=%0b exp=%0b", c, tick_out, exp_tick()); end
            if (tick_out === 1'b1) begin
                highs++;
                total++; if (pending_empty !== 1'b0) begin bad++; $display("FAIL drain_bits_at_tick got=%0b exp=0", pending_empty); end
            end
            @(negedge clk);
        end
        total++; if (highs != 1) begin bad++; $display("FAIL drain_tick_width got=%0d exp=1", highs); end
        pulse_set();
        axon_num = 8'd20; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL drain_bit20 got=%0b exp=1", axon_spike); end
        axon_num = 8'd21; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL drain_bit21 got=%0b exp=1", axon_spike); end
        // Empty FIFO: tick must appear exactly one cycle after tick_in.
        @(negedge clk); tick_in = 1'b1; #1;
        total++; if (tick_out !== 1'b0) begin bad++; $display("FAIL min_lat_same got=%0b exp=0", tick_out); end
        @(negedge clk); tick_in = 1'b0; #1;
        total++; if (tick_out !== 1'b1) begin bad++; $display("FAIL min_lat_next got=%0b exp=1", tick_out); end
        @(negedge clk); #1;
        total++; if (tick_out !== 1'b0) begin bad++; $display("FAIL min_lat_after got=%0b exp=0", tick_out); end
    endtask

    task automatic test_double_tick();
        int highs;
        highs = 0;
        apply_reset();
        wait_packets = 1'b0;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0; #1;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL dtick_first_error got=%0b exp=0", error); end
        total++; if (tick_out !== 1'b0) begin bad++; $display("FAIL dtick_busy_tick got=%0b exp=0", tick_out); end
        @(negedge clk);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0; #1;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL dtick_error got=%0b exp=1", error); end
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL dtick_drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        repeat (2) @(negedge clk);
        wait_packets = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (tick_out === 1'b1) highs++;
            @(negedge clk);
        end
        total++; if (highs != 1) begin bad++; $display("FAIL dtick_single got=%0d exp=1", highs); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        wait_packets = 1'b1;
        push_one(8'd199);
        repeat (3) @(negedge clk);
        #1;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL oor_199_error got=%0b exp=0", error); end
        total++; if (pending_empty !== 1'b0) begin bad++; $display("FAIL oor_199_pending got=%0b exp=0", pending_empty); end
        push_one(8'd250);
        repeat (3) @(negedge clk);
        #1;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL oor_250_error got=%0b exp=1", error); end
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL oor_250_drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        push_one(8'd200);
        repeat (3) @(negedge clk);
        #1;
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL oor_200_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
        pulse_set();
        axon_num = 8'd199; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL oor_bit199 got=%0b exp=1", axon_spike); end
        for (int a = 0; a < 256; a++) begin
            axon_num = 8'(a); #1;
            total++; if (axon_spike !== exp_spike()) begin bad++; $display("FAIL oor_map axon=%0d got=%0b exp=%0b", a, axon_spike, exp_spike()); end
        end
    endtask

    task automatic test_clr();
        apply_reset();
        wait_packets = 1'b1;
        push_one(8'd5);
        repeat (3) @(negedge clk);
        pulse_set();
        axon_num = 8'd5; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL clr_before got=%0b exp=1", axon_spike); end
        @(negedge clk); scheduler_clr = 1'b1;
        @(negedge clk); scheduler_clr = 1'b0; #1;
        total++; if (axon_spike !== 1'b0) begin bad++; $display("FAIL clr_after got=%0b exp=0", axon_spike); end
        push_one(8'd9);
        repeat (3) @(negedge clk);
        @(negedge clk); scheduler_set = 1'b1; scheduler_clr = 1'b1;
        @(negedge clk); scheduler_set = 1'b0; scheduler_clr = 1'b0;
        axon_num = 8'd9; #1;
        total++; if (axon_spike !== 1'b1) begin bad++; $display("FAIL setclr_bit9 got=%0b exp=1", axon_spike); end
        axon_num = 8'd5; #1;
        total++; if (axon_spike !== 1'b0) begin bad++; $display("FAIL setclr_bit5 got=%0b exp=0", axon_spike); end
        total++; if (pending_empty !== 1'b1) begin bad++; $display("FAIL setclr_pending got=%0b exp=1", pending_empty); end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 3; blk++) begin
            apply_reset();
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                pkt_valid     = ($urandom_range(0, 2) != 0);
                pkt_axon      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                                            : 8'($urandom_range(0, 31));
                wait_packets  = ($urandom_range(0, 3) != 0);
                tick_in       = ($urandom_range(0, 11) == 0);
                scheduler_set = ($urandom_range(0, 7) == 0);
                scheduler_clr = ($urandom_range(0, 9) == 0);
                axon_num      = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
                #1;
                total++; if (pkt_ready !== exp_ready()) begin bad++; $display("FAIL rnd_pkt_ready c=%0d got=%0b exp=%0b", c, pkt_ready, exp_ready()); end
                total++; if (tick_out !== exp_tick()) begin bad++; $display("FAIL rnd_tick_out c=%0d got=%0b exp=%0b", c, tick_out, exp_tick()); end
                total++; if (axon_spike !== exp_spike()) begin bad++; $display("FAIL rnd_axon_spike c=%0d axon=%0d got=%0b exp=%0b", c, axon_num, axon_spike, exp_spike()); end
                total++; if (pending_empty !== exp_pempty()) begin bad++; $display("FAIL rnd_pending_empty c=%0d got=%0b exp=%0b", c, pending_empty, exp_pempty()); end
                total++; if (error !== m_err) begin bad++; $display("FAIL rnd_error c=%0d got=%0b exp=%0b", c, error, m_err); end
`ifdef SPIKE_SCHEDULER_DROP_CNT_EN
                total++; if (drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop_cnt c=%0d got=%0d exp=%0d", c, drop_cnt, m_drop); end
`endif
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Sequencer and watchdog
    // -------------------------------------------------------------------------
    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b1;
        wait_packets = 1'b0;
        axon_num     = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_tick_drain();
        test_double_tick();
        test_out_of_range();
        test_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
